mac_combiner_pipe: RTL and testbench

//  Pipelined, parametrised combiner: merges LANES accumulator partials into groups of 2^cfg lanes
//  (single/dual/quad/.../all), each group = sum of partial_k << (k_in_group*SHIFT_W).

---
 rtl/mac_combiner_pipe_pkg.sv | 27 ++
 rtl/mac_combiner_stage.sv | 84 ++++++++
 rtl/mac_combiner_pipe.sv | 77 +++++++
 tb/tb_mac_combiner_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_combiner_pipe_pkg.sv
// ============================================================================
// mac_combiner_pipe_pkg : mode codes and width defaults for the MAC combiner
// Rev 1.0
// ============================================================================
`default_nettype none

package mac_combiner_pipe_pkg;

  // cfg encodes log2 of the group size in lanes
  localparam int MAC_SINGLE    = 0;
  localparam int MAC_DUAL      = 1;
  localparam int MAC_QUAD      = 2;
  localparam int MAC_ACC_WIDTH = 32;
  localparam int MAC_MIN_WIDTH = 8;

  // Group sizes beyond the tree depth fall back to single-lane pass-through.
  function automatic int unsigned clamp_cfg(input int unsigned cfg, input int unsigned levels);
    return (cfg > levels) ? int'(MAC_SINGLE) : cfg;
  endfunction

  function automatic int unsigned group_lanes(input int unsigned cfg);
    return (cfg == MAC_QUAD) ? 4 : (cfg == MAC_DUAL) ? 2 : (1 << cfg);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_combiner_stage.sv
// ============================================================================
// mac_combiner_stage : one level of the lane-merge tree plus its pipeline regs
// Optional MAC_COMBINER_SIGNED_EN: sign-extend blocks before shift/add.
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_combiner_stage
  import mac_combiner_pipe_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int LANE_W  = MAC_ACC_WIDTH,
  parameter int SHIFT_W = MAC_MIN_WIDTH,
  parameter int LEVEL   = 0,
  parameter int CFG_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic [CFG_W-1:0]        in_cfg,
  input  logic [LANES*LANE_W-1:0] in_data,
  output logic                    out_valid,
  output logic [CFG_W-1:0]        out_cfg,
  output logic [LANES*LANE_W-1:0] out_data
);

  localparam int DATA_W = LANES * LANE_W;
  localparam int BLK_W  = (2 ** LEVEL) * LANE_W;
  localparam int PAIR_W = 2 * BLK_W;
  localparam int NPAIRS = DATA_W / PAIR_W;
  localparam int SH     = (2 ** LEVEL) * SHIFT_W;

  logic              merge_en;
  logic [DATA_W-1:0] merged;

  assign merge_en = (in_cfg > CFG_W'(LEVEL));

  generate
    for (genvar b = 0; b < NPAIRS; b++) begin : g_pair
      logic [BLK_W-1:0]  lo;
      logic [BLK_W-1:0]  hi;
      logic [PAIR_W-1:0] lo_x;
      logic [PAIR_W-1:0] hi_x;
      logic [PAIR_W-1:0] sum;

      assign lo = in_data[b*PAIR_W +: BLK_W];
      assign hi = in_data[b*PAIR_W + BLK_W +: BLK_W];
`ifdef MAC_COMBINER_SIGNED_EN
      assign lo_x = {{BLK_W{lo[BLK_W-1]}}, lo};
      assign hi_x = {{BLK_W{hi[BLK_W-1]}}, hi};
`else
      assign lo_x = {{BLK_W{1'b0}}, lo};
      assign hi_x = {{BLK_W{1'b0}}, hi};
`endif
      // Upper block carries the higher weight; sum wraps at the merged width.
      assign sum = lo_x + (hi_x << SH);
      assign merged[b*PAIR_W +: PAIR_W] = merge_en ? sum : in_data[b*PAIR_W +: PAIR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cfg   <= '0;
      out_data  <= '0;
    end else begin
      // Flush wins over hold; payload registers are left to go stale.
      if (clr) begin
        out_valid <= 1'b0;
      end else if (en) begin
        out_valid <= in_valid;
      end
      if (en) begin
        out_cfg  <= in_cfg;
        out_data <= merged;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mac_combiner_pipe.sv
// ============================================================================
// mac_combiner_pipe : pipelined lane combiner, one tree level per stage
// Optional MAC_COMBINER_SIGNED_EN: two's complement partials.
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_combiner_pipe
  import mac_combiner_pipe_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int LANE_W  = MAC_ACC_WIDTH,
  parameter int SHIFT_W = MAC_MIN_WIDTH,
  parameter int LEVELS  = $clog2(LANES),
  parameter int CFG_W   = $clog2(LEVELS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CFG_W-1:0]        cfg,
  input  logic [LANES*LANE_W-1:0] partials,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CFG_W-1:0]        out_cfg,
  output logic [LANES*LANE_W-1:0] outs
);

  localparam int DATA_W = LANES * LANE_W;

  logic              advance;
  logic [CFG_W-1:0]  cfg_eff;
  logic [LEVELS:0]   v;
  logic [CFG_W-1:0]  c [LEVELS+1];
  logic [DATA_W-1:0] d [LEVELS+1];

  assign cfg_eff  = CFG_W'(clamp_cfg(32'(cfg), LEVELS));

  // Single global enable: the whole pipe either shifts or holds.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign v[0] = in_valid;
  assign c[0] = cfg_eff;
  assign d[0] = partials;

  generate
    for (genvar l = 0; l < LEVELS; l++) begin : g_level
      mac_combiner_stage #(
        .LANES   (LANES),
        .LANE_W  (LANE_W),
        .SHIFT_W (SHIFT_W),
        .LEVEL   (l),
        .CFG_W   (CFG_W)
      ) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (advance),
        .in_valid  (v[l]),
        .in_cfg    (c[l]),
        .in_data   (d[l]),
        .out_valid (v[l+1]),
        .out_cfg   (c[l+1]),
        .out_data  (d[l+1])
      );
    end
  endgenerate

  assign out_valid = v[LEVELS];
  assign out_cfg   = c[LEVELS];
  assign outs      = d[LEVELS];

endmodule

`default_nettype wire

// File: tb/tb_mac_combiner_pipe.sv
// ============================================================================
// tb_mac_combiner_pipe : directed + random scoreboard bench for the combiner
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mac_combiner_pipe;

  localparam int LANES   = 4;
  localparam int LANE_W  = 32;
  localparam int SHIFT_W = 8;
  localparam int LEVELS  = 2;
  localparam int CFG_W   = 2;
  localparam int DW      = LANES * LANE_W;

  typedef struct packed {
    logic [CFG_W-1:0] cfg;
    logic [DW-1:0]    outs;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [CFG_W-1:0] cfg;
  logic [DW-1:0]    partials;
  logic             out_valid;
  logic             out_ready;
  logic [CFG_W-1:0] out_cfg;
  logic [DW-1:0]    outs;

  exp_t             sb[$];
  exp_t             head;
  logic [DW-1:0]    nxt_outs;
  logic [CFG_W-1:0] nxt_cfg;
  logic             acc;
  int               checks = 0;
  int               errors = 0;

  mac_combiner_pipe #(
    .LANES   (LANES),
    .LANE_W  (LANE_W),
    .SHIFT_W (SHIFT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg       (cfg),
    .partials  (partials),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cfg   (out_cfg),
    .outs      (outs)
  );

  always #5 clk = ~clk;

  // Direct weighted sum per group, independent of the tree structure.
  function automatic logic [DW-1:0] model(input logic [CFG_W-1:0] c, input logic [DW-1:0] p);
    int            ce;
    int            g_sz;
    logic [DW-1:0] r;
    logic [DW-1:0] a;
    logic [DW-1:0] x;
    logic [DW:0]   one;
    logic [DW-1:0] mask;
    logic [LANE_W-1:0] pl;
    ce   = (int'(c) > LEVELS) ? 0 : int'(c);
    g_sz = 1 << ce;
    r    = '0;
    one  = 1;
    mask = DW'((one << (g_sz * LANE_W)) - 1);
    for (int g = 0; g < LANES / g_sz; g++) begin
      a = '0;
      for (int k = 0; k < g_sz; k++) begin
        pl = p[(g*g_sz + k)*LANE_W +: LANE_W];
`ifdef MAC_COMBINER_SIGNED_EN
        x = {{(DW-LANE_W){pl[LANE_W-1]}}, pl};
`else
        x = {{(DW-LANE_W){1'b0}}, pl};
`endif
        a = a + (x << (k * SHIFT_W));
      end
      r = r | ((a & mask) << (g * g_sz * LANE_W));
    end
    return r;
  endfunction

  function automatic logic [CFG_W-1:0] eff(input logic [CFG_W-1:0] c);
    return (int'(c) > LEVELS) ? '0 : c;
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe at negedge, score output, record accepted beat.
  task automatic tick();
    @(negedge clk);
    acc = 1'b0;
    if (out_valid === 1'b1) begin
      chk("spurious_out_valid", DW'(sb.size() == 0), '0);
      if (sb.size() != 0) begin
        chk("outs", outs, sb[0].outs);
        chk("out_cfg", DW'(out_cfg), DW'(sb[0].cfg));
        if (out_ready) head = sb.pop_front();
      end
      if (!out_ready) chk("in_ready_stall", DW'(in_ready), '0);
    end else begin
      chk("in_ready_idle", DW'(in_ready), DW'(1));
    end
    if (rst_n && !clr && in_valid && in_ready) begin
      sb.push_back('{cfg: nxt_cfg, outs: nxt_outs});
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [CFG_W-1:0] c, input logic [DW-1:0] p,
                       input logic [DW-1:0] e, input logic [CFG_W-1:0] ec);
    in_valid = 1'b1;
    cfg      = c;
    partials = p;
    nxt_outs = e;
    nxt_cfg  = ec;
  endtask

  logic [DW-1:0] p;
  logic [CFG_W-1:0] cr;
  int beat;

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg = '0; partials = '0; nxt_outs = '0; nxt_cfg = '0;
    #12;
    chk("reset_out_valid", DW'(out_valid), '0);
    chk("reset_outs", outs, '0);
    chk("reset_out_cfg", DW'(out_cfg), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reset_in_ready", DW'(in_ready), DW'(1));

    // single mode, exact latency
    drive(2'd0, {32'd4, 32'd3, 32'd2, 32'd1}, {32'd4, 32'd3, 32'd2, 32'd1}, 2'd0);
    tick();
    chk("single_accept", DW'(acc), DW'(1));
    in_valid = 1'b0;
    chk("single_lat1", DW'(out_valid), '0);
    tick();
    chk("single_lat2", DW'(out_valid), DW'(1));
    tick();

    // dual, quad, out-of-range cfg
    drive(2'd1, {32'h02, 32'h10, 32'h01, 32'hFF}, {32'd0, 32'h210, 32'd0, 32'h1FF}, 2'd1);
    tick();
    drive(2'd2, {32'd1, 32'd1, 32'd1, 32'd1}, {32'd0, 32'd0, 32'd0, 32'h01010101}, 2'd2);
    tick();
    drive(2'd3, {32'd8, 32'd7, 32'd6, 32'd5}, {32'd8, 32'd7, 32'd6, 32'd5}, 2'd0);
    tick();
`ifdef MAC_COMBINER_SIGNED_EN
    drive(2'd1, {32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}, {64'd0, 64'hFFFFFFFF_FFFFFF00}, 2'd1);
`else
    drive(2'd1, {32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}, {64'd0, 64'h000000FF_FFFFFF00}, 2'd1);
`endif
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("directed_drained", DW'(sb.size()), '0);

    // backpressure: out_ready low in cycles 3..6
    beat = 0;
    for (int i = 0; i < 40 && (beat < 5 || sb.size() != 0); i++) begin
      out_ready = !(i >= 3 && i <= 6);
      if (beat < 5) begin
        p = rnd128();
        cr = CFG_W'(beat % 2);
        drive(cr, p, model(cr, p), eff(cr));
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (acc) beat++;
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    chk("bp_beats_sent", DW'(beat), DW'(5));
    chk("bp_drained", DW'(sb.size()), '0);

    // async reset with two beats in flight
    drive(2'd0, 128'hA, 128'hA, 2'd0);
    tick();
    drive(2'd1, 128'hB, 128'hB, 2'd1);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", DW'(out_valid), '0);
    chk("rst_mid_outs", outs, '0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // clr drops in-flight beat and the beat offered with it
    drive(2'd0, 128'hC, 128'hC, 2'd0);
    tick();
    drive(2'd0, 128'hD, 128'hD, 2'd0);
    clr = 1'b1;
    tick();
    chk("clr_in_ready", DW'(in_ready), DW'(1));
    clr = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) tick();
    p = {32'h44, 32'h33, 32'h22, 32'h11};
    drive(2'd2, p, model(2'd2, p), 2'd2);
    tick();
    in_valid = 1'b0;
    chk("clr_next_lat1", DW'(out_valid), '0);
    tick();
    chk("clr_next_lat2", DW'(out_valid), DW'(1));
    tick();

    // random traffic vs model
    for (int i = 0; i < 80; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) != 0) begin
        p  = rnd128();
        cr = CFG_W'($urandom_range(0, 3));
        drive(cr, p, model(cr, p), eff(cr));
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("random_drained", DW'(sb.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
